// File: rtl/emu_time_mgr_pkg.sv
// Shared types and default widths for the emulation time manager.
package emu_time_pkg;

  localparam int DEF_N_OSC      = 2;
  localparam int DEF_DT_WIDTH   = 27;
  localparam int DEF_TIME_WIDTH = 39;

  // Host control mode; encoding is fixed by the debug host protocol.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT      = 2'd1,
    RUN_UNTIL = 2'd2,
    STEP      = 2'd3
  } ctrl_mode_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/emu_time_mgr_if.sv
// Request/control/status bundle between the debug host + oscillator blocks
// (master side) and the emulation time manager (slave side).
interface emu_time_mgr_if #(
  parameter int N_OSC      = 2,
  parameter int DT_WIDTH   = 27,
  parameter int TIME_WIDTH = 39
);

  logic [N_OSC*DT_WIDTH-1:0] dt_req;
  emu_time_pkg::ctrl_mode_t  ctrl_mode;
  logic [TIME_WIDTH-1:0]     stop_time;
  logic                      step_pulse;
  logic [TIME_WIDTH-1:0]     emu_time;
  logic [DT_WIDTH-1:0]       emu_dt;
  logic [N_OSC-1:0]          clk_val;
  logic                      emu_stall;
  logic                      done;

  modport master (
    output dt_req, ctrl_mode, stop_time, step_pulse,
    input  emu_time, emu_dt, clk_val, emu_stall, done
  );

  modport slave (
    input  dt_req, ctrl_mode, stop_time, step_pulse,
    output emu_time, emu_dt, clk_val, emu_stall, done
  );

endinterface

// File: rtl/emu_time_mgr_dt_min_tree.sv
// Log-depth minimum over the active (non-zero) time-step requests.
// Inactive and padding leaves are forced to all-ones so they never win;
// when nothing is active the caller substitutes its own fallback step.
module emu_dt_min_tree #(
  parameter int N_OSC    = 2,
  parameter int DT_WIDTH = 27
) (
  input  logic [N_OSC*DT_WIDTH-1:0] dt_req,
  output logic [DT_WIDTH-1:0]       dt_min,
  output logic                      any_active
);

  localparam int LEVELS = (N_OSC > 1) ? $clog2(N_OSC) : 0;
  localparam int LEAVES = 1 << LEVELS;

  genvar l, j;
  for (l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int W = LEAVES >> l;
    logic [DT_WIDTH-1:0] vals [W];
    if (l == 0) begin : g_leaf
      for (j = 0; j < W; j++) begin : g_j
        if (j < N_OSC) begin : g_real
          assign vals[j] = (dt_req[j*DT_WIDTH +: DT_WIDTH] != '0)
                         ? dt_req[j*DT_WIDTH +: DT_WIDTH] : '1;
        end else begin : g_pad
          assign vals[j] = '1;
        end
      end
    end else begin : g_node
      for (j = 0; j < W; j++) begin : g_j
        assign vals[j] = (g_lvl[l-1].vals[2*j] <= g_lvl[l-1].vals[2*j+1])
                       ? g_lvl[l-1].vals[2*j] : g_lvl[l-1].vals[2*j+1];
      end
    end
  end

  assign dt_min = g_lvl[LEVELS].vals[0];

  // Flag whether any requester is asking for a step at all.
  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < N_OSC; i++) begin
      any_active = any_active | (dt_req[i*DT_WIDTH +: DT_WIDTH] != '0);
    end
  end

endmodule

// File: rtl/emu_time_mgr.sv
// Emulation time manager: picks the smallest requested time step each
// emu_clk cycle, advances global emulated time by it and raises the clock
// enables of the oscillators whose request was met. Run/halt/run-until/step
// sequencing for the debug host lives here too.
module emu_time_mgr
  import emu_time_pkg::*;
#(
  parameter int              N_OSC      = DEF_N_OSC,
  parameter int              DT_WIDTH   = DEF_DT_WIDTH,
  parameter int              TIME_WIDTH = DEF_TIME_WIDTH,
  parameter logic [DT_WIDTH-1:0] DT_MAX = {DT_WIDTH{1'b1}}
) (
  input logic           emu_clk,
  input logic           emu_rst,
  emu_time_mgr_if.slave bus
);

  state_t                state;
  logic [TIME_WIDTH-1:0] emu_time_q;
  logic [DT_WIDTH-1:0]   emu_dt_q;
  logic [N_OSC-1:0]      clk_val_q;
  logic                  stall_q;
  logic                  done_q;

  logic [DT_WIDTH-1:0]   tree_min;
  logic                  any_active;
  logic [DT_WIDTH-1:0]   dt_min;
  logic [DT_WIDTH-1:0]   dt_sel;
  logic [TIME_WIDTH-1:0] rem;
  logic                  rem_zero;
  logic [N_OSC-1:0]      match;
  logic                  adv;

  emu_dt_min_tree #(
    .N_OSC    (N_OSC),
    .DT_WIDTH (DT_WIDTH)
  ) u_dt_min_tree (
    .dt_req     (bus.dt_req),
    .dt_min     (tree_min),
    .any_active (any_active)
  );

  // Choose the step: smallest active request, clipped so run-until lands exactly on stop_time.
  always_comb begin
    dt_min   = any_active ? tree_min : DT_MAX;
    rem      = bus.stop_time - emu_time_q;
    rem_zero = (rem == '0);
    dt_sel   = dt_min;
    if (bus.ctrl_mode == RUN_UNTIL && rem < TIME_WIDTH'(dt_min)) begin
      dt_sel = rem[DT_WIDTH-1:0];
    end
  end

  // An oscillator gets an edge only when its own active request is the step taken.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_OSC; i++) begin
      match[i] = (bus.dt_req[i*DT_WIDTH +: DT_WIDTH] != '0) &&
                 (bus.dt_req[i*DT_WIDTH +: DT_WIDTH] == dt_sel);
    end
  end

  // Decide whether time advances this cycle from the state and host mode.
  always_comb begin
    adv = 1'b0;
    case (state)
      S_HALT: adv = (bus.ctrl_mode == STEP) && bus.step_pulse;
      S_RUN: begin
        if (bus.ctrl_mode == RUN) begin
          adv = 1'b1;
        end else if (bus.ctrl_mode == RUN_UNTIL) begin
          adv = !rem_zero;
        end
      end
      default: adv = 1'b0;
    endcase
  end

  // Sequencer state, the sticky done flag and the registered time outputs.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      state      <= S_HALT;
      emu_time_q <= '0;
      emu_dt_q   <= '0;
      clk_val_q  <= '0;
      stall_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_HALT: begin
          if (bus.ctrl_mode == RUN || bus.ctrl_mode == RUN_UNTIL) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.ctrl_mode == HALT || bus.ctrl_mode == STEP) begin
            state <= S_HALT;
          end else if (bus.ctrl_mode == RUN_UNTIL && rem_zero) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.ctrl_mode == HALT) begin
            state  <= S_HALT;
            done_q <= 1'b0;
          end
        end
        default: state <= S_HALT;
      endcase

      if (adv) begin
        emu_dt_q   <= dt_sel;
        emu_time_q <= emu_time_q + TIME_WIDTH'(dt_sel);
        clk_val_q  <= match;
        stall_q    <= 1'b0;
      end else begin
        emu_dt_q   <= '0;
        clk_val_q  <= '0;
        stall_q    <= 1'b1;
      end
    end
  end

  assign bus.emu_time  = emu_time_q;
  assign bus.emu_dt    = emu_dt_q;
  assign bus.clk_val   = clk_val_q;
  assign bus.emu_stall = stall_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_emu_time_mgr.sv
// Self-checking bench for emu_time_mgr: directed scenarios plus a randomized
// run, all compared against a cycle model of the time manager's rules.
module tb_emu_time_mgr;
  import emu_time_pkg::*;

  localparam int NO = 2;
  localparam int DW = 27;
  localparam int TW = 39;
  localparam logic [DW-1:0] DTMAX = {DW{1'b1}};

  logic emu_clk = 1'b0;
  logic emu_rst = 1'b1;
  int   checks  = 0;
  int   passes  = 0;

  emu_time_mgr_if #(.N_OSC(NO), .DT_WIDTH(DW), .TIME_WIDTH(TW)) tb_if ();

  emu_time_mgr #(.N_OSC(NO), .DT_WIDTH(DW), .TIME_WIDTH(TW)) dut (
    .emu_clk (emu_clk),
    .emu_rst (emu_rst),
    .bus     (tb_if)
  );

  always #5 emu_clk = ~emu_clk;

  // Reference model state: 0 halted, 1 running, 2 finished run-until.
  int            m_phase;
  logic [TW-1:0] m_time;
  logic [DW-1:0] m_dt;
  logic [NO-1:0] m_clk;
  logic          m_stall;
  logic          m_done;

  task automatic set_req(input logic [DW-1:0] r1, input logic [DW-1:0] r0);
    tb_if.dt_req = {r1, r0};
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    logic [DW-1:0] r, dmin, sel;
    logic [TW-1:0] rem;
    logic          any, go;
    if (emu_rst) begin
      m_phase = 0; m_time = '0; m_dt = '0; m_clk = '0; m_stall = 1'b1; m_done = 1'b0;
      return;
    end
    any = 1'b0;
    dmin = DTMAX;
    for (int i = 0; i < NO; i++) begin
      r = tb_if.dt_req[i*DW +: DW];
      if (r != 0 && (!any || r < dmin)) dmin = r;
      if (r != 0) any = 1'b1;
    end
    rem = tb_if.stop_time - m_time;
    sel = dmin;
    if (tb_if.ctrl_mode == RUN_UNTIL && rem < TW'(dmin)) sel = DW'(rem);
    go = 1'b0;
    if (m_phase == 0) begin
      go = (tb_if.ctrl_mode == STEP) && tb_if.step_pulse;
      if (tb_if.ctrl_mode == RUN || tb_if.ctrl_mode == RUN_UNTIL) m_phase = 1;
    end else if (m_phase == 1) begin
      if (tb_if.ctrl_mode == RUN) go = 1'b1;
      else if (tb_if.ctrl_mode == RUN_UNTIL) begin
        if (rem == 0) begin m_phase = 2; m_done = 1'b1; end
        else go = 1'b1;
      end else m_phase = 0;
    end else if (tb_if.ctrl_mode == HALT) begin
      m_phase = 0;
      m_done  = 1'b0;
    end
    if (go) begin
      m_dt = sel;
      m_time = m_time + TW'(sel);
      for (int i = 0; i < NO; i++) begin
        r = tb_if.dt_req[i*DW +: DW];
        m_clk[i] = (r != 0) && (r == sel);
      end
      m_stall = 1'b0;
    end else begin
      m_dt = '0; m_clk = '0; m_stall = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge emu_clk);
    #1;
  endtask

  task automatic test_reset();
    emu_rst = 1'b1;
    tb_if.ctrl_mode = HALT; tb_if.step_pulse = 1'b0; tb_if.stop_time = '0;
    set_req(27'd0, 27'd0);
    tick(); tick();
    checks++;
    if ({tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done} !==
        {{TW{1'b0}}, {DW{1'b0}}, 2'b00, 1'b1, 1'b0})
      $display("[TB] FAIL reset_values: got time=%0d dt=%0d clk_val=%b stall=%b done=%b, want 0 0 00 1 0",
               tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done);
    else passes++;
    emu_rst = 1'b0;
  endtask

  task automatic test_run_basic();
    tb_if.ctrl_mode = RUN;
    set_req(27'd500, 27'd300);
    tick();
    checks++;
    if (tb_if.emu_stall !== 1'b1 || tb_if.emu_time !== '0)
      $display("[TB] FAIL run_entry: got stall=%b time=%0d, want 1 0", tb_if.emu_stall, tb_if.emu_time);
    else passes++;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (tb_if.emu_dt !== 27'd300 || tb_if.clk_val !== 2'b01 || tb_if.emu_time !== TW'(300 * k))
        $display("[TB] FAIL run_step%0d: got dt=%0d clk_val=%b time=%0d, want 300 01 %0d",
                 k, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_time, 300 * k);
      else passes++;
    end
    set_req(27'd0, 27'd0);
    tick();
    checks++;
    if (tb_if.emu_dt !== DTMAX || tb_if.clk_val !== 2'b00 || tb_if.emu_time !== m_time)
      $display("[TB] FAIL run_idle: got dt=%0d clk_val=%b time=%0d, want %0d 00 %0d",
               tb_if.emu_dt, tb_if.clk_val, tb_if.emu_time, DTMAX, m_time);
    else passes++;
    set_req(27'd200, 27'd200);
    tick();
    checks++;
    if (tb_if.emu_dt !== 27'd200 || tb_if.clk_val !== 2'b11)
      $display("[TB] FAIL run_tie: got dt=%0d clk_val=%b, want 200 11", tb_if.emu_dt, tb_if.clk_val);
    else passes++;
  endtask

  task automatic test_run_until();
    int exp_dt [4] = '{300, 300, 300, 100};
    logic [1:0] exp_cv [4] = '{2'b11, 2'b11, 2'b11, 2'b00};
    emu_rst = 1'b1; tick(); emu_rst = 1'b0;
    tb_if.ctrl_mode = RUN_UNTIL; tb_if.stop_time = TW'(1000);
    set_req(27'd300, 27'd300);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (tb_if.emu_dt !== DW'(exp_dt[k]) || tb_if.clk_val !== exp_cv[k] || tb_if.emu_time !== m_time)
        $display("[TB] FAIL until_step%0d: got dt=%0d clk_val=%b time=%0d, want %0d %b %0d",
                 k, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_time, exp_dt[k], exp_cv[k], m_time);
      else passes++;
    end
    checks++;
    if (tb_if.emu_time !== TW'(1000))
      $display("[TB] FAIL until_land: got time=%0d, want 1000", tb_if.emu_time);
    else passes++;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (tb_if.done !== 1'b1 || tb_if.emu_stall !== 1'b1 || tb_if.emu_dt !== '0 ||
          tb_if.emu_time !== TW'(1000))
        $display("[TB] FAIL until_done%0d: got done=%b stall=%b dt=%0d time=%0d, want 1 1 0 1000",
                 k, tb_if.done, tb_if.emu_stall, tb_if.emu_dt, tb_if.emu_time);
      else passes++;
    end
    tb_if.stop_time = TW'(5000);
    tick();
    checks++;
    if (tb_if.done !== 1'b1 || tb_if.emu_time !== TW'(1000))
      $display("[TB] FAIL done_sticky: got done=%b time=%0d, want 1 1000", tb_if.done, tb_if.emu_time);
    else passes++;
    tb_if.ctrl_mode = HALT;
    tick();
    checks++;
    if (tb_if.done !== 1'b0 || tb_if.emu_stall !== 1'b1)
      $display("[TB] FAIL done_clear: got done=%b stall=%b, want 0 1", tb_if.done, tb_if.emu_stall);
    else passes++;
  endtask

  task automatic test_step();
    emu_rst = 1'b1; tick(); emu_rst = 1'b0;
    tb_if.ctrl_mode = STEP; tb_if.step_pulse = 1'b0;
    set_req(27'd40, 27'd70);
    tick();
    for (int k = 1; k <= 3; k++) begin
      tb_if.step_pulse = 1'b1;
      tick();
      checks++;
      if (tb_if.emu_time !== TW'(40 * k) || tb_if.clk_val !== 2'b10 || tb_if.emu_stall !== 1'b0)
        $display("[TB] FAIL step_pulse%0d: got time=%0d clk_val=%b stall=%b, want %0d 10 0",
                 k, tb_if.emu_time, tb_if.clk_val, tb_if.emu_stall, 40 * k);
      else passes++;
      tb_if.step_pulse = 1'b0;
      set_req(27'($urandom_range(1, 999)), 27'($urandom_range(1, 999)));
      tick();
      checks++;
      if (tb_if.emu_stall !== 1'b1 || tb_if.emu_time !== TW'(40 * k) || tb_if.emu_dt !== '0)
        $display("[TB] FAIL step_gap%0d: got stall=%b time=%0d dt=%0d, want 1 %0d 0",
                 k, tb_if.emu_stall, tb_if.emu_time, tb_if.emu_dt, 40 * k);
      else passes++;
      set_req(27'd40, 27'd70);
    end
    tb_if.step_pulse = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (tb_if.emu_time !== m_time || tb_if.emu_stall !== 1'b0)
        $display("[TB] FAIL step_held%0d: got time=%0d stall=%b, want %0d 0",
                 k, tb_if.emu_time, tb_if.emu_stall, m_time);
      else passes++;
    end
    tb_if.step_pulse = 1'b0;
  endtask

  task automatic test_wrap();
    emu_rst = 1'b1; tick(); emu_rst = 1'b0;
    tb_if.ctrl_mode = RUN;
    set_req(DTMAX, DTMAX);
    tick();
    for (int k = 0; k < 4096; k++) tick();
    checks++;
    if (tb_if.emu_time !== 39'h7F_FFFF_F000 || tb_if.emu_time !== m_time)
      $display("[TB] FAIL wrap_pre: got time=%h, want 7ffffff000", tb_if.emu_time);
    else passes++;
    tick();
    checks++;
    if (tb_if.emu_time !== TW'(134213631) || tb_if.clk_val !== 2'b11 || tb_if.emu_dt !== DTMAX)
      $display("[TB] FAIL wrap_post: got time=%0d clk_val=%b dt=%0d, want 134213631 11 %0d",
               tb_if.emu_time, tb_if.clk_val, tb_if.emu_dt, DTMAX);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    emu_rst = 1'b1; tick(); emu_rst = 1'b0;
    tb_if.ctrl_mode = RUN;
    set_req(27'd300, 27'd300);
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (tb_if.emu_time !== TW'(900))
      $display("[TB] FAIL midrun_time: got time=%0d, want 900", tb_if.emu_time);
    else passes++;
    tb_if.ctrl_mode = RUN_UNTIL; tb_if.stop_time = TW'(900);
    tick();
    checks++;
    if (tb_if.done !== 1'b1)
      $display("[TB] FAIL midrun_done: got done=%b, want 1", tb_if.done);
    else passes++;
    emu_rst = 1'b1;
    tick();
    checks++;
    if ({tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done} !==
        {{TW{1'b0}}, {DW{1'b0}}, 2'b00, 1'b1, 1'b0})
      $display("[TB] FAIL midrun_reset: got time=%0d dt=%0d clk_val=%b stall=%b done=%b, want 0 0 00 1 0",
               tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done);
    else passes++;
    emu_rst = 1'b0;
    tb_if.ctrl_mode = RUN;
    tick();
    checks++;
    if (tb_if.emu_stall !== 1'b1 || tb_if.emu_time !== '0)
      $display("[TB] FAIL midrun_halted: got stall=%b time=%0d, want 1 0", tb_if.emu_stall, tb_if.emu_time);
    else passes++;
    tick();
    checks++;
    if (tb_if.emu_time !== TW'(300))
      $display("[TB] FAIL midrun_resume: got time=%0d, want 300", tb_if.emu_time);
    else passes++;
  endtask

  task automatic test_random();
    logic [DW-1:0] r0, r1;
    emu_rst = 1'b1; tick(); emu_rst = 1'b0;
    tb_if.stop_time = TW'(2000);
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0:       tb_if.ctrl_mode = HALT;
        1, 2:    tb_if.ctrl_mode = STEP;
        3, 4, 5: tb_if.ctrl_mode = RUN_UNTIL;
        default: tb_if.ctrl_mode = RUN;
      endcase
      tb_if.step_pulse = 1'($urandom_range(0, 1));
      r0 = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 1000));
      r1 = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 1000));
      if ($urandom_range(0, 4) == 0) r1 = r0;
      set_req(r1, r0);
      if ($urandom_range(0, 9) == 0) tb_if.stop_time = m_time + TW'($urandom_range(0, 2500));
      tick();
      checks++;
      if ({tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done} !==
          {m_time, m_dt, m_clk, m_stall, m_done})
        $display("[TB] FAIL random%0d: got time=%0d dt=%0d clk_val=%b stall=%b done=%b, want %0d %0d %b %b %b",
                 k, tb_if.emu_time, tb_if.emu_dt, tb_if.clk_val, tb_if.emu_stall, tb_if.done,
                 m_time, m_dt, m_clk, m_stall, m_done);
      else passes++;
    end
  endtask

  // Keep a broken design from running forever.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_run_basic();
    test_run_until();
    test_step();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
